mem_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between the IF fetch port and the MEM-stage load/store port.
- Latches each winning request, drives the memory-side request/ack handshake, and returns completion pulses plus data to the two requesters.
- The MEM port has priority, with an anti-starvation limit for IF.
- Sits between the IF/MEM pipeline stages and the unified memory instance inside the memory top.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_priority.sv | 32 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned MEM_ARB_ADDR_W     = 32;
   localparam int unsigned MEM_ARB_DATA_W     = 32;
   localparam int unsigned STARVE_MAX_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2
   } mem_arb_state_t;

   // Latched winning request, held on the o_ram_* outputs for the whole transaction.
   typedef struct packed {
      logic                      we;
      logic [MEM_ARB_ADDR_W-1:0] addr;
      logic [MEM_ARB_DATA_W-1:0] wrData;
   } mem_arb_req_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational winner select: MEM has priority unless IF has been starved STARVE_MAX times.
module mem_arb_priority
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic       i_if_req,
   input  logic       i_mem_req,
   input  logic [3:0] i_starve_cnt,
   output logic       o_grant_if,
   output logic       o_grant_mem
);

   localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

   always_comb begin
      o_grant_if  = 1'b0;
      o_grant_mem = 1'b0;
      if (i_if_req && i_mem_req) begin
         if (i_starve_cnt < StarveLim) begin
            o_grant_mem = 1'b1;
         end else begin
            o_grant_if = 1'b1;
         end
      end else if (i_if_req) begin
         o_grant_if = 1'b1;
      end else if (i_mem_req) begin
         o_grant_mem = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the IF fetch port and MEM load/store port onto one single-port memory.
// Optional MEM_ARB_PERF_EN adds stall/conflict performance counters.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   // The latched-request struct is sized by the package widths; overrides must match.
   parameter int unsigned ADDR_W     = MEM_ARB_ADDR_W,
   parameter int unsigned DATA_W     = MEM_ARB_DATA_W,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_instr,
   output logic              o_if_done,
   input  logic              i_mem_req,
   input  logic              i_mem_we,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wrData,
   output logic [DATA_W-1:0] o_mem_rdData,
   output logic              o_mem_done,
   output logic              o_ram_req,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wrData,
   input  logic              i_ram_ack,
   input  logic [DATA_W-1:0] i_ram_rdData
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       o_perf_ifStall,
   output logic [31:0]       o_perf_conflict
`endif
);

   localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

   mem_arb_state_t    state_q, state_d;
   mem_arb_req_t      lat_q, lat_d;
   logic [3:0]        starve_q, starve_d;
   logic              ram_req_q, ram_req_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic [DATA_W-1:0] if_instr_q, if_instr_d;
   logic [DATA_W-1:0] mem_rd_q, mem_rd_d;

   logic if_req_m, mem_req_m;
   logic grant_if, grant_mem;

   // A req seen during its own done cycle is the finished transaction, not a new one.
   assign if_req_m  = i_if_req & ~if_done_q;
   assign mem_req_m = i_mem_req & ~mem_done_q;

   mem_arb_priority #(
      .STARVE_MAX (STARVE_MAX)
   ) u_priority (
      .i_if_req     (if_req_m),
      .i_mem_req    (mem_req_m),
      .i_starve_cnt (starve_q),
      .o_grant_if   (grant_if),
      .o_grant_mem  (grant_mem)
   );

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      starve_d   = starve_q;
      ram_req_d  = ram_req_q;
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      if_instr_d = if_instr_q;
      mem_rd_d   = mem_rd_q;
      case (state_q)
         IDLE: begin
            if (grant_mem) begin
               lat_d.we     = i_mem_we;
               lat_d.addr   = i_mem_addr;
               lat_d.wrData = i_mem_wrData;
               ram_req_d    = 1'b1;
               state_d      = BUSY_MEM;
               if (i_if_req && (starve_q < StarveLim)) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (grant_if) begin
               lat_d.we     = 1'b0;
               lat_d.addr   = i_if_addr;
               lat_d.wrData = '0;
               ram_req_d    = 1'b1;
               state_d      = BUSY_IF;
               starve_d     = '0;
            end
         end
         BUSY_IF: begin
            if (i_ram_ack) begin
               ram_req_d  = 1'b0;
               if_done_d  = 1'b1;
               if_instr_d = i_ram_rdData;
               state_d    = IDLE;
            end
         end
         BUSY_MEM: begin
            if (i_ram_ack) begin
               ram_req_d  = 1'b0;
               mem_done_d = 1'b1;
               if (!lat_q.we) begin
                  mem_rd_d = i_ram_rdData;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= IDLE;
         lat_q      <= '0;
         starve_q   <= '0;
         ram_req_q  <= 1'b0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         if_instr_q <= '0;
         mem_rd_q   <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         starve_q   <= starve_d;
         ram_req_q  <= ram_req_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
         if_instr_q <= if_instr_d;
         mem_rd_q   <= mem_rd_d;
      end
   end

   assign o_ram_req    = ram_req_q;
   assign o_ram_we     = lat_q.we;
   assign o_ram_addr   = lat_q.addr;
   assign o_ram_wrData = lat_q.wrData;
   assign o_if_done    = if_done_q;
   assign o_mem_done   = mem_done_q;
   assign o_if_instr   = if_instr_q;
   assign o_mem_rdData = mem_rd_q;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] if_stall_q, if_stall_d;
   logic [31:0] conflict_q, conflict_d;

   always_comb begin
      if_stall_d = if_stall_q;
      conflict_d = conflict_q;
      if (if_req_m) begin
         if_stall_d = if_stall_q + 32'd1;
      end
      if ((state_q == IDLE) && if_req_m && mem_req_m) begin
         conflict_d = conflict_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         if_stall_q <= '0;
         conflict_q <= '0;
      end else begin
         if_stall_q <= if_stall_d;
         conflict_q <= conflict_d;
      end
   end

   assign o_perf_ifStall  = if_stall_q;
   assign o_perf_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for mem_arbiter.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, mem_req, mem_we, ram_ack;
   logic [31:0] if_addr, mem_addr, mem_wd, ram_rd;
   logic [31:0] if_instr, mem_rd, ram_addr, ram_wd;
   logic        if_done, mem_done, ram_req, ram_we;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_if_req     (if_req),
      .i_if_addr    (if_addr),
      .o_if_instr   (if_instr),
      .o_if_done    (if_done),
      .i_mem_req    (mem_req),
      .i_mem_we     (mem_we),
      .i_mem_addr   (mem_addr),
      .i_mem_wrData (mem_wd),
      .o_mem_rdData (mem_rd),
      .o_mem_done   (mem_done),
      .o_ram_req    (ram_req),
      .o_ram_we     (ram_we),
      .o_ram_addr   (ram_addr),
      .o_ram_wrData (ram_wd),
      .i_ram_ack    (ram_ack),
      .i_ram_rdData (ram_rd)
   );

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wd;
      logic        ack;
      logic [31:0] rd;
      logic        e_req;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic        e_ifd;
      logic        e_memd;
      logic [31:0] e_instr;
      logic [31:0] e_mrd;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req   = 1'b0;
      if_addr  = '0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_wd   = '0;
      ram_ack  = 1'b0;
      ram_rd   = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      #2;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ram_req"}, 32'(ram_req), 32'h0);
      check({tag, "_ram_we"}, 32'(ram_we), 32'h0);
      check({tag, "_ram_addr"}, ram_addr, 32'h0);
      check({tag, "_ram_wd"}, ram_wd, 32'h0);
      check({tag, "_if_done"}, 32'(if_done), 32'h0);
      check({tag, "_mem_done"}, 32'(mem_done), 32'h0);
      check({tag, "_if_instr"}, if_instr, 32'h0);
      check({tag, "_mem_rd"}, mem_rd, 32'h0);
   endtask

   initial begin
      logic [31:0] grants[$];
      logic        prev_req;

      // ifr  ifaddr        mr    we    maddr         mwd           ack   rd
      //   -> req  we    addr          wd            ifd   memd  instr         mrd
      vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
      vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h00500093,
                   1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h00500093, 32'h0};
      vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'h0};
      vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,
                   1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00500093, 32'h0};
      vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h12345678,
                   1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h00500093, 32'h0};
      vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00500093, 32'h0};
      vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'h0};
      vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF,
                   1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 32'h00500093, 32'hDEADBEEF};
      vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'hDEADBEEF};
      vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF,
                   1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'hDEADBEEF};
      vecs[10] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'hDEADBEEF};
      vecs[11] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'hAAAA0001,
                   1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1, 32'h00500093, 32'hAAAA0001};
      vecs[12] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h00500093, 32'hAAAA0001};
      vecs[13] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBBBB0002,
                   1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'hBBBB0002, 32'hAAAA0001};
      vecs[14] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'hBBBB0002, 32'hAAAA0001};
      vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'hBBBB0002, 32'hAAAA0001};

      rst = 1'b1;
      idle_inputs();
      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         if_req   = vecs[i].if_req;
         if_addr  = vecs[i].if_addr;
         mem_req  = vecs[i].mem_req;
         mem_we   = vecs[i].mem_we;
         mem_addr = vecs[i].mem_addr;
         mem_wd   = vecs[i].mem_wd;
         ram_ack  = vecs[i].ack;
         ram_rd   = vecs[i].rd;
         step();
         check($sformatf("v%0d_ram_req", i), 32'(ram_req), 32'(vecs[i].e_req));
         check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
         check($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
         check($sformatf("v%0d_ram_wd", i), ram_wd, vecs[i].e_wd);
         check($sformatf("v%0d_if_done", i), 32'(if_done), 32'(vecs[i].e_ifd));
         check($sformatf("v%0d_mem_done", i), 32'(mem_done), 32'(vecs[i].e_memd));
         check($sformatf("v%0d_if_instr", i), if_instr, vecs[i].e_instr);
         check($sformatf("v%0d_mem_rd", i), mem_rd, vecs[i].e_mrd);
      end

      // Both held high: masking of the just-served port makes service alternate.
      do_reset();
      if_req   = 1'b1;
      if_addr  = 32'h600;
      mem_req  = 1'b1;
      mem_addr = 32'h500;
      prev_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         ram_ack = ram_req;
         ram_rd  = 32'hC0DE0000 + 32'(i);
         step();
         check($sformatf("alt%0d_done_overlap", i), 32'(if_done & mem_done), 32'h0);
         if (ram_req && !prev_req) grants.push_back(ram_addr);
         prev_req = ram_req;
      end
      check("alt_grant_count", 32'(grants.size()), 32'd6);
      for (int i = 0; i < 6 && i < grants.size(); i++) begin
         check($sformatf("alt_grant%0d", i), grants[i], (i % 2 == 0) ? 32'h500 : 32'h600);
      end

      // Starvation: four MEM wins with IF pending, then IF is forced through.
      do_reset();
      mem_req  = 1'b1;
      mem_addr = 32'h700;
      if_addr  = 32'h800;
      for (int k = 0; k < 4; k++) begin
         if_req  = 1'b1;
         ram_ack = 1'b0;
         step();
         check($sformatf("starve%0d_grant_req", k), 32'(ram_req), 32'h1);
         check($sformatf("starve%0d_grant_addr", k), ram_addr, 32'h700);
         ram_ack = 1'b1;
         step();
         check($sformatf("starve%0d_mem_done", k), 32'(mem_done), 32'h1);
         if_req  = 1'b0;
         ram_ack = 1'b0;
         step();
         check($sformatf("starve%0d_gap", k), 32'(ram_req), 32'h0);
      end
      if_req = 1'b1;
      step();
      check("starve_if_forced_req", 32'(ram_req), 32'h1);
      check("starve_if_forced_addr", ram_addr, 32'h800);
      ram_ack = 1'b1;
      ram_rd  = 32'h0000_0013;
      step();
      check("starve_if_done", 32'(if_done), 32'h1);
      check("starve_if_instr", if_instr, 32'h0000_0013);
      ram_ack = 1'b0;
      step();
      check("starve_mem_again_addr", ram_addr, 32'h700);
      check("starve_mem_again_req", 32'(ram_req), 32'h1);

      // Wait states with the requester's inputs changing mid-transaction.
      do_reset();
      mem_req  = 1'b1;
      mem_we   = 1'b1;
      mem_addr = 32'h300;
      mem_wd   = 32'h11223344;
      step();
      check("ws_grant_addr", ram_addr, 32'h300);
      for (int j = 0; j < 5; j++) begin
         mem_addr = 32'h999 + 32'(j);
         mem_wd   = ~32'(j);
         mem_we   = 1'b0;
         if_req   = 1'b1;
         if_addr  = 32'h40;
         step();
         check($sformatf("ws%0d_req", j), 32'(ram_req), 32'h1);
         check($sformatf("ws%0d_addr", j), ram_addr, 32'h300);
         check($sformatf("ws%0d_we", j), 32'(ram_we), 32'h1);
         check($sformatf("ws%0d_wd", j), ram_wd, 32'h11223344);
         check($sformatf("ws%0d_dones", j), 32'({if_done, mem_done}), 32'h0);
      end
      ram_ack = 1'b1;
      ram_rd  = 32'hBAD0BAD0;
      step();
      check("ws_mem_done", 32'(mem_done), 32'h1);
      check("ws_ack_req_drop", 32'(ram_req), 32'h0);
      check("ws_store_keeps_rd", mem_rd, 32'h0);
      mem_req = 1'b0;
      ram_ack = 1'b0;
      step();
      check("ws_pending_if_addr", ram_addr, 32'h40);
      check("ws_pending_if_req", 32'(ram_req), 32'h1);
      ram_ack = 1'b1;
      ram_rd  = 32'h0000_0067;
      step();
      check("ws_if_done", 32'(if_done), 32'h1);

      // Reset while BUSY_MEM abandons the access without a done pulse.
      do_reset();
      mem_req  = 1'b1;
      mem_addr = 32'h900;
      step();
      check("rb_busy_req", 32'(ram_req), 32'h1);
      ram_ack = 1'b1;
      ram_rd  = 32'h77777777;
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("rb_async");
      step();
      check("rb_no_mem_done", 32'(mem_done), 32'h0);
      check("rb_no_mem_rd", mem_rd, 32'h0);
      rst      = 1'b0;
      mem_req  = 1'b0;
      ram_ack  = 1'b0;
      if_req   = 1'b1;
      if_addr  = 32'h44;
      step();
      check("rb_if_grant_req", 32'(ram_req), 32'h1);
      check("rb_if_grant_addr", ram_addr, 32'h44);
      ram_ack = 1'b1;
      ram_rd  = 32'h55;
      step();
      check("rb_if_done", 32'(if_done), 32'h1);
      check("rb_if_instr", if_instr, 32'h55);
      check("rb_mem_done_quiet", 32'(mem_done), 32'h0);
      idle_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
